// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, receiver state encoding and counter width helper
package uart_pkg;
  localparam int D_WIDTH_DEF = 9;
  typedef enum logic [1:0] {IDLE, DATA, STOP, WAIT_IDLE} rx_state_t;
  function automatic int cnt_width(input int d);
    return $clog2(d + 1);
  endfunction
endpackage

// File: rtl/uart_sync.sv
// uart_sync: two-flop synchronizer with configurable reset value
module uart_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1;
  always_ff @(posedge clk)
    if (rst) {q, s1} <= {2{RST_VAL}};
    else {q, s1} <= {s1, d};
endmodule

// File: rtl/uart_receive.sv
// uart_receive: 1-sample-per-clk UART receiver with valid/ready output; UART_RECEIVE_OVERRUN_EN drops frames instead of overwriting
module uart_receive
  import uart_pkg::*;
#(
  parameter int D_WIDTH = D_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx,
  output logic [D_WIDTH-1:0] rx_data,
  output logic               rx_valid,
  input  logic               rx_ready,
  output logic               rx_busy,
  output logic               frame_err,
  output logic               overrun
);
  localparam int CW = cnt_width(D_WIDTH);
  rx_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [D_WIDTH-1:0] shreg, shreg_n, data_n;
  logic s2, good, drop, valid_n, ferr_n, ovr, ovr_n;
  uart_sync #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(rx), .q(s2));
  assign rx_busy = state != IDLE;
  assign overrun = ovr;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    shreg_n = shreg;
    ferr_n = 1'b0;
    good = 1'b0;
    case (state)
      IDLE: begin
        state_n = s2 ? IDLE : DATA;
        cnt_n = '0;
      end
      DATA: begin
        shreg_n = D_WIDTH'({s2, shreg} >> 1);
        cnt_n = cnt + 1'b1;
        state_n = cnt == CW'(D_WIDTH - 1) ? STOP : DATA;
      end
      STOP: begin
        good = s2;
        ferr_n = !s2;
        state_n = s2 ? IDLE : WAIT_IDLE;
      end
      default: state_n = s2 ? IDLE : WAIT_IDLE;
    endcase
`ifdef UART_RECEIVE_OVERRUN_EN
    drop = good && rx_valid && !rx_ready;
`else
    drop = 1'b0;
`endif
    ovr_n = ovr | drop;
    data_n = good && !drop ? shreg : rx_data;
    valid_n = good || (rx_valid && !rx_ready);
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      ovr <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      shreg <= shreg_n;
      rx_data <= data_n;
      rx_valid <= valid_n;
      frame_err <= ferr_n;
      ovr <= ovr_n;
    end
endmodule
